// File: rtl/data_mem_pkg.sv
// Shared definitions for the handshaked data memory: funct3 codes, FSM
// states and the size/alignment legality check.
package data_mem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        RESP = 2'b10
    } state_t;

    // Size/sign/alignment legality. Only the two low address bits matter
    // here; the word-range check depends on DEPTH and is done in the top.
    function automatic logic is_legal(input logic we, input logic [2:0] funct3,
                                      input logic [1:0] addr);
        logic legal_s;
        case (funct3)
            F3_B:    legal_s = 1'b1;
            F3_H:    legal_s = ~addr[0];
            F3_W:    legal_s = (addr == 2'b00);
            F3_BU:   legal_s = ~we;
            F3_HU:   legal_s = ~we & ~addr[0];
            default: legal_s = 1'b0;
        endcase
        return legal_s;
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Little-endian lane steering: store byte enables and data replication,
// load lane selection with sign or zero extension.
module mem_lane_align
    import data_mem_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]      funct3,
    input  logic [1:0]      lane,
    input  logic [XLEN-1:0] wdata,
    input  logic [XLEN-1:0] rword,
    output logic [3:0]      be,
    output logic [XLEN-1:0] wrep,
    output logic [XLEN-1:0] rext
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Pick the addressed byte and halfword out of the stored word.
    always_comb begin
        byte_s = rword[{lane, 3'b000} +: 8];
        half_s = rword[{lane[1], 4'b0000} +: 16];
    end

    // Decode size into lane enables, replicated store data and extended load data.
    always_comb begin
        be   = 4'b0000;
        wrep = {XLEN{1'b0}};
        rext = {XLEN{1'b0}};
        case (funct3)
            F3_B: begin
                be   = 4'b0001 << lane;
                wrep = {4{wdata[7:0]}};
                rext = {{(XLEN-8){byte_s[7]}}, byte_s};
            end
            F3_BU: begin
                be   = 4'b0001 << lane;
                wrep = {4{wdata[7:0]}};
                rext = {{(XLEN-8){1'b0}}, byte_s};
            end
            F3_H: begin
                be   = lane[1] ? 4'b1100 : 4'b0011;
                wrep = {2{wdata[15:0]}};
                rext = {{(XLEN-16){half_s[15]}}, half_s};
            end
            F3_HU: begin
                be   = lane[1] ? 4'b1100 : 4'b0011;
                wrep = {2{wdata[15:0]}};
                rext = {{(XLEN-16){1'b0}}, half_s};
            end
            F3_W: begin
                be   = 4'b1111;
                wrep = wdata;
                rext = rword;
            end
            default: begin
                be   = 4'b0000;
                wrep = {XLEN{1'b0}};
                rext = {XLEN{1'b0}};
            end
        endcase
    end

endmodule

// File: rtl/data_mem_hs.sv
// Handshaked RV32I data memory with configurable wait states. A request is
// taken in IDLE, optionally waits in BUSY, and commits (write and registered
// read) on the edge entering RESP, where a one-cycle response is presented.
module data_mem_hs
    import data_mem_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int DEPTH  = 64,
    parameter int ADDR_W = 8,
    parameter int WAIT   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [XLEN-1:0]   req_wdata,
    output logic              rsp_valid,
    output logic [XLEN-1:0]   rsp_rdata,
    output logic              rsp_err
);

    localparam int         IDX_W  = ADDR_W - 2;
    localparam int         MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0] WAIT_L = 4'(WAIT);

    state_t            state_r;
    logic [3:0]        cnt_r;
    logic              we_r;
    logic [2:0]        f3_r;
    logic [ADDR_W-1:0] addr_r;
    logic [XLEN-1:0]   wdata_r;
    logic              req_ready_r;
    logic              rsp_valid_r;
    logic [XLEN-1:0]   rsp_rdata_r;
    logic              rsp_err_r;
    logic [XLEN-1:0]   mem_r [DEPTH];

    logic              cur_we_s;
    logic [2:0]        cur_f3_s;
    logic [ADDR_W-1:0] cur_addr_s;
    logic [XLEN-1:0]   cur_wdata_s;
    logic [IDX_W-1:0]  idx_s;
    logic              in_range_s;
    logic              ok_s;
    logic              commit_s;
    logic [XLEN-1:0]   rd_word_s;
    logic [3:0]        be_s;
    logic [XLEN-1:0]   wrep_s;
    logic [XLEN-1:0]   rext_s;

    // With zero wait states the commit happens on the accept edge, so the
    // live request is used directly; otherwise the latched copy is used.
    always_comb begin
        if (state_r == IDLE) begin
            cur_we_s    = req_we;
            cur_f3_s    = req_funct3;
            cur_addr_s  = req_addr;
            cur_wdata_s = req_wdata;
        end else begin
            cur_we_s    = we_r;
            cur_f3_s    = f3_r;
            cur_addr_s  = addr_r;
            cur_wdata_s = wdata_r;
        end
    end

    // Range/legality check, array read and the commit-edge condition.
    always_comb begin
        idx_s      = cur_addr_s[ADDR_W-1:2];
        in_range_s = (32'(idx_s) < 32'(DEPTH));
        ok_s       = is_legal(cur_we_s, cur_f3_s, cur_addr_s[1:0]) & in_range_s;
        if (in_range_s) begin
            rd_word_s = mem_r[idx_s[MEM_AW-1:0]];
        end else begin
            rd_word_s = {XLEN{1'b0}};
        end
        if (WAIT == 0) begin
            commit_s = (state_r == IDLE) & req_valid;
        end else begin
            commit_s = (state_r == BUSY) & ((cnt_r + 4'd1) == WAIT_L);
        end
    end

    mem_lane_align #(.XLEN(XLEN)) u_align (
        .funct3 (cur_f3_s),
        .lane   (cur_addr_s[1:0]),
        .wdata  (cur_wdata_s),
        .rword  (rd_word_s),
        .be     (be_s),
        .wrep   (wrep_s),
        .rext   (rext_s)
    );

    // Access FSM, wait counter, data array and response registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r     <= IDLE;
            cnt_r       <= 4'd0;
            we_r        <= 1'b0;
            f3_r        <= 3'b000;
            addr_r      <= {ADDR_W{1'b0}};
            wdata_r     <= {XLEN{1'b0}};
            req_ready_r <= 1'b1;
            rsp_valid_r <= 1'b0;
            rsp_rdata_r <= {XLEN{1'b0}};
            rsp_err_r   <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {XLEN{1'b0}};
            end
        end else begin
            rsp_valid_r <= 1'b0;
            rsp_rdata_r <= {XLEN{1'b0}};
            rsp_err_r   <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (req_valid) begin
                        we_r        <= req_we;
                        f3_r        <= req_funct3;
                        addr_r      <= req_addr;
                        wdata_r     <= req_wdata;
                        cnt_r       <= 4'd0;
                        req_ready_r <= 1'b0;
                        state_r     <= (WAIT == 0) ? RESP : BUSY;
                    end
                end
                BUSY: begin
                    cnt_r <= cnt_r + 4'd1;
                    if ((cnt_r + 4'd1) == WAIT_L) begin
                        state_r <= RESP;
                    end
                end
                RESP: begin
                    state_r     <= IDLE;
                    req_ready_r <= 1'b1;
                end
                default: begin
                    state_r     <= IDLE;
                    req_ready_r <= 1'b1;
                end
            endcase
            if (commit_s) begin
                rsp_valid_r <= 1'b1;
                if (ok_s) begin
                    rsp_err_r   <= 1'b0;
                    rsp_rdata_r <= cur_we_s ? {XLEN{1'b0}} : rext_s;
                    if (cur_we_s) begin
                        for (int b = 0; b < 4; b++) begin
                            if (be_s[b]) begin
                                mem_r[idx_s[MEM_AW-1:0]][8*b +: 8] <= wrep_s[8*b +: 8];
                            end
                        end
                    end
                end else begin
                    rsp_err_r   <= 1'b1;
                    rsp_rdata_r <= {XLEN{1'b0}};
                end
            end
        end
    end

    assign req_ready = req_ready_r;
    assign rsp_valid = rsp_valid_r;
    assign rsp_rdata = rsp_rdata_r;
    assign rsp_err   = rsp_err_r;

endmodule

// File: tb/tb_data_mem_hs.sv
// Scoreboard bench for data_mem_hs: three instances (WAIT=1 with a 9-bit
// address so out-of-range words are reachable, WAIT=0, WAIT=3). A byte-level
// reference model predicts every response; a monitor checks them.
module tb_data_mem_hs;

    typedef struct {
        bit [31:0] rdata;
        bit        err;
        int        due;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid  [3];
    logic        req_ready  [3];
    logic        req_we     [3];
    logic [2:0]  req_funct3 [3];
    logic [8:0]  req_addr   [3];
    logic [31:0] req_wdata  [3];
    logic        rsp_valid  [3];
    logic [31:0] rsp_rdata  [3];
    logic        rsp_err    [3];

    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    int   last_acc [3];
    bit [7:0] ref_b [3][512];
    exp_t sb_q [3][$];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    data_mem_hs #(.XLEN(32), .DEPTH(64), .ADDR_W(9), .WAIT(1)) u_dut0 (
        .clk(clk), .rst(rst), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .req_we(req_we[0]), .req_funct3(req_funct3[0]), .req_addr(req_addr[0]),
        .req_wdata(req_wdata[0]), .rsp_valid(rsp_valid[0]), .rsp_rdata(rsp_rdata[0]),
        .rsp_err(rsp_err[0]));

    data_mem_hs #(.XLEN(32), .DEPTH(64), .ADDR_W(8), .WAIT(0)) u_dut1 (
        .clk(clk), .rst(rst), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .req_we(req_we[1]), .req_funct3(req_funct3[1]), .req_addr(req_addr[1][7:0]),
        .req_wdata(req_wdata[1]), .rsp_valid(rsp_valid[1]), .rsp_rdata(rsp_rdata[1]),
        .rsp_err(rsp_err[1]));

    data_mem_hs #(.XLEN(32), .DEPTH(64), .ADDR_W(8), .WAIT(3)) u_dut2 (
        .clk(clk), .rst(rst), .req_valid(req_valid[2]), .req_ready(req_ready[2]),
        .req_we(req_we[2]), .req_funct3(req_funct3[2]), .req_addr(req_addr[2][7:0]),
        .req_wdata(req_wdata[2]), .rsp_valid(rsp_valid[2]), .rsp_rdata(rsp_rdata[2]),
        .rsp_err(rsp_err[2]));

    function automatic int wait_of(input int d);
        case (d)
            0:       return 1;
            1:       return 0;
            default: return 3;
        endcase
    endfunction

    task automatic chk(input string name, input int d, input bit [63:0] act, input bit [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s dut=%0d actual=0x%0h required=0x%0h at cycle %0d", name, d, act, exp, cyc);
        end
    endtask

    // Reference model over a byte array: size, sign and legality from the
    // RV32I rules, little-endian byte order, 64 words per instance.
    function automatic void model(input int d, input bit we, input bit [2:0] f3, input int addr,
                                  input bit [31:0] wd, output bit [31:0] rd, output bit err);
        int size = 0;
        bit sgn = 1'b0;
        bit [31:0] v = 32'd0;
        case (f3)
            3'd0: begin size = 1; sgn = 1'b1; end
            3'd1: begin size = 2; sgn = 1'b1; end
            3'd2: begin size = 4; sgn = 1'b1; end
            3'd4: begin size = 1; sgn = 1'b0; end
            3'd5: begin size = 2; sgn = 1'b0; end
            default: size = 0;
        endcase
        err = (size == 0);
        if (!err) err = (we && (f3 == 3'd4 || f3 == 3'd5)) || (addr % size != 0) || (addr / 4 >= 64);
        rd = 32'd0;
        if (!err) begin
            if (we) begin
                for (int i = 0; i < size; i++) ref_b[d][addr+i] = wd[8*i +: 8];
            end else begin
                for (int i = 0; i < size; i++) v = v | (32'(ref_b[d][addr+i]) << (8*i));
                if (sgn && size < 4 && v[8*size-1]) v = v | (32'hFFFF_FFFF << (8*size));
                rd = v;
            end
        end
    endfunction

    // Issue one request at a negedge while ready; the following posedge accepts it.
    task automatic send(input int d, input bit we, input bit [2:0] f3, input int addr,
                        input bit [31:0] wd, input bit hold, input bit track);
        int n = 0;
        int acc;
        exp_t e;
        while (!req_ready[d] && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready[d]) begin
            checks++;
            failures++;
            $display("FAIL ready_timeout dut=%0d actual ready=0 required ready=1", d);
            return;
        end
        req_we[d]     = we;
        req_funct3[d] = f3;
        req_addr[d]   = addr[8:0];
        req_wdata[d]  = wd;
        req_valid[d]  = 1'b1;
        acc = cyc + 1;
        if (track) begin
            model(d, we, f3, addr, wd, e.rdata, e.err);
            e.due = acc + wait_of(d);
            sb_q[d].push_back(e);
        end
        if (hold && last_acc[d] >= 0) chk("accept_spacing", d, 64'(acc - last_acc[d]), 64'(wait_of(d) + 2));
        last_acc[d] = acc;
        @(negedge clk);
        if (!hold) req_valid[d] = 1'b0;
    endtask

    task automatic rand_op(input int d, input bit hold);
        bit [2:0] f3 = 3'($urandom_range(0, 7));
        bit we = 1'($urandom_range(0, 1));
        int addr;
        if (d == 0 && $urandom_range(0, 9) == 0) addr = 256 + $urandom_range(0, 15);
        else addr = $urandom_range(0, 63);
        send(d, we, f3, addr, $urandom, hold, 1'b1);
    endtask

    task automatic clear_model();
        for (int d = 0; d < 3; d++) begin
            for (int a = 0; a < 512; a++) ref_b[d][a] = 8'd0;
            sb_q[d].delete();
        end
    endtask

    // Monitor: every response must match the head of its queue in cycle and
    // data; outputs must read zero when no response is presented.
    always @(negedge clk) begin
        exp_t e;
        for (int d = 0; d < 3; d++) begin
            if (rst) begin
                if (rsp_valid[d]) begin
                    if (sb_q[d].size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL spurious_rsp dut=%0d actual rsp_valid=1 required 0 at cycle %0d", d, cyc);
                    end else begin
                        e = sb_q[d].pop_front();
                        chk("rsp_cycle", d, 64'(cyc), 64'(e.due));
                        chk("rsp_rdata", d, 64'(rsp_rdata[d]), 64'(e.rdata));
                        chk("rsp_err", d, 64'(rsp_err[d]), 64'(e.err));
                    end
                end else begin
                    chk("idle_outputs_zero", d, {31'd0, rsp_err[d], rsp_rdata[d]}, 64'd0);
                    if (sb_q[d].size() != 0 && sb_q[d][0].due < cyc) begin
                        e = sb_q[d].pop_front();
                        checks++;
                        failures++;
                        $display("FAIL missing_rsp dut=%0d actual none required rsp at cycle %0d", d, e.due);
                    end
                end
            end
        end
    end

    initial begin
        int n;
        for (int d = 0; d < 3; d++) begin
            req_valid[d] = 1'b0; req_we[d] = 1'b0; req_funct3[d] = 3'd0;
            req_addr[d] = 9'd0; req_wdata[d] = 32'd0; last_acc[d] = -1;
        end
        clear_model();
        #2 rst = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        for (int d = 0; d < 3; d++) chk("ready_after_reset", d, 64'(req_ready[d]), 64'd1);

        // Directed sequence on the WAIT=1 instance.
        send(0, 1'b0, 3'd2, 32'h00, 32'd0, 1'b0, 1'b1);
        send(0, 1'b1, 3'd2, 32'h10, 32'h80FF7F01, 1'b0, 1'b1);
        send(0, 1'b0, 3'd0, 32'h10, 32'd0, 1'b0, 1'b1);
        send(0, 1'b0, 3'd0, 32'h11, 32'd0, 1'b0, 1'b1);
        send(0, 1'b0, 3'd4, 32'h12, 32'd0, 1'b0, 1'b1);
        send(0, 1'b0, 3'd1, 32'h12, 32'd0, 1'b0, 1'b1);
        send(0, 1'b0, 3'd5, 32'h12, 32'd0, 1'b0, 1'b1);
        send(0, 1'b0, 3'd2, 32'h10, 32'd0, 1'b0, 1'b1);
        send(0, 1'b1, 3'd2, 32'h20, 32'h11223344, 1'b0, 1'b1);
        send(0, 1'b1, 3'd0, 32'h21, 32'hFFFFFFAB, 1'b0, 1'b1);
        send(0, 1'b0, 3'd2, 32'h20, 32'd0, 1'b0, 1'b1);
        // Error cases, then reads proving memory is untouched.
        send(0, 1'b1, 3'd2, 32'h22, 32'hCAFEF00D, 1'b0, 1'b1);
        send(0, 1'b1, 3'd1, 32'h13, 32'h00005555, 1'b0, 1'b1);
        send(0, 1'b1, 3'd3, 32'h10, 32'h12345678, 1'b0, 1'b1);
        send(0, 1'b1, 3'd0, 32'h100, 32'h000000EE, 1'b0, 1'b1);
        send(0, 1'b1, 3'd4, 32'h20, 32'h000000EE, 1'b0, 1'b1);
        send(0, 1'b0, 3'd2, 32'h20, 32'd0, 1'b0, 1'b1);
        send(0, 1'b0, 3'd2, 32'h10, 32'd0, 1'b0, 1'b1);
        for (int i = 0; i < 60; i++) rand_op(0, 1'b0);

        // Reset during BUSY of a store: no response, no write.
        repeat (4) @(negedge clk);
        send(0, 1'b1, 3'd2, 32'h04, 32'hDEADBEEF, 1'b0, 1'b0);
        rst = 1'b0;
        clear_model();
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("ready_after_abort", 0, 64'(req_ready[0]), 64'd1);
        send(0, 1'b0, 3'd2, 32'h04, 32'd0, 1'b0, 1'b1);

        // Back-to-back with req_valid held high on WAIT=0 and WAIT=3.
        last_acc[1] = -1;
        for (int i = 0; i < 12; i++) rand_op(1, 1'b1);
        req_valid[1] = 1'b0;
        last_acc[2] = -1;
        for (int i = 0; i < 10; i++) rand_op(2, 1'b1);
        req_valid[2] = 1'b0;

        n = 0;
        while ((sb_q[0].size() + sb_q[1].size() + sb_q[2].size()) != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("drain", 0, 64'(sb_q[0].size() + sb_q[1].size() + sb_q[2].size()), 64'd0);
        repeat (5) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
